// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding and default sizing for the stopwatch controller
package stopwatch_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE} state_t;
  localparam int TICK_DIV = 50000;
  localparam int NUM_DIGITS = 4;
endpackage

// File: rtl/stopwatch_ctrl_tick_gen.sv
// tick_gen: prescaler producing a registered one-cycle tick every TICK_DIV run cycles
module tick_gen #(
  parameter int TICK_DIV = stopwatch_pkg::TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic zero,
  output logic tick_q
);
  import stopwatch_pkg::*;
  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  logic [W-1:0] r_div_cnt;
  // count only while running, hold otherwise so a paused period resumes mid-way
  always_ff @(posedge clk) begin
    if (rst || zero) r_div_cnt <= '0;
    else if (run) r_div_cnt <= (r_div_cnt == LAST) ? '0 : r_div_cnt + 1'b1;
  end
  // tick fires the cycle after the last count of a period
  always_ff @(posedge clk) begin
    if (rst) tick_q <= 1'b0;
    else tick_q <= run && (r_div_cnt == LAST);
  end
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/idle sequencer for a cascaded digit chain; lap freeze enabled by STOPWATCH_LAP_EN
module stopwatch_ctrl #(
  parameter int NUM_DIGITS = stopwatch_pkg::NUM_DIGITS,
  parameter int TICK_DIV = stopwatch_pkg::TICK_DIV
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_stop,
  input  logic                  clear,
  input  logic                  lap,
  input  logic [NUM_DIGITS-1:0] co_in,
  output logic [NUM_DIGITS-1:0] clk_en_out,
  output logic                  inc_out,
  output logic                  clr_out,
  output logic                  running,
  output logic                  lap_hold,
  output logic                  overflow
);
  import stopwatch_pkg::*;
  state_t r_state;
  logic r_running, r_clr, r_overflow;
  logic w_tick, w_run, w_zero, w_wrap;
  logic [NUM_DIGITS-1:0] w_en;
  assign w_run = (r_state == ST_RUN);
  assign w_zero = clear || (r_state == ST_IDLE);
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .run   (w_run),
    .zero  (w_zero),
    .tick_q(w_tick)
  );
  assign w_en[0] = w_tick;
  for (genvar g = 1; g < NUM_DIGITS; g++) begin : g_ripple
    assign w_en[g] = w_en[g-1] & co_in[g-1];
  end
  assign w_wrap = w_tick & (&co_in);
  // state machine, clear strobe and sticky overflow; clear overrides everything else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_running <= 1'b0;
      r_clr <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_clr <= clear;
      if (clear) begin
        r_state <= ST_IDLE;
        r_running <= 1'b0;
        r_overflow <= 1'b0;
      end else begin
        if (start_stop) begin
          r_state <= w_run ? ST_PAUSE : ST_RUN;
          r_running <= !w_run;
        end
        if (w_wrap) r_overflow <= 1'b1;
      end
    end
  end
`ifdef STOPWATCH_LAP_EN
  logic r_lap_hold;
  // lap toggles the freeze only while running; leaving to idle drops it
  always_ff @(posedge clk) begin
    if (rst || clear) r_lap_hold <= 1'b0;
    else if (lap && w_run) r_lap_hold <= ~r_lap_hold;
  end
  assign lap_hold = r_lap_hold;
`else
  logic w_lap_unused;
  assign w_lap_unused = lap;
  assign lap_hold = 1'b0;
`endif
  assign clk_en_out = w_en;
  assign inc_out = w_tick;
  assign clr_out = r_clr;
  assign running = r_running;
  assign overflow = r_overflow;
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Controller that sequences a chain of NUM_DIGITS cascaded mod-10 digit counters to form a stopwatch. Each digit counter has the ports clk_en, inc, clr and co.
- It owns the run/pause/idle state machine and a prescaler that produces one tick every TICK_DIV clocks.
- It builds the per-digit clock-enable ripple from the counters' carry-outs.
- It issues synchronous clears, tracks overflow and manages a lap (display freeze) flag.
- It sits between the debounced button pulses and the digit counter chain.

## Interface
- NUM_DIGITS, 4: number of cascaded digit counters controlled; must be ≥1.
- TICK_DIV, 50000: clock cycles per count tick; must be ≥2.

- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start_stop  in  1  one-cycle pulse that toggles between run and pause.
- clear  in  1  one-cycle pulse that returns the block to idle and zeroes the counters.
- lap  in  1  one-cycle pulse that toggles lap_hold.
- co_in  in  NUM_DIGITS  carry-out of each digit counter; bit 0 is the least significant digit.
- clk_en_out  out  NUM_DIGITS  per-digit enable, driven to each counter's clk_en.
- inc_out  out  1  increment strobe, driven to every counter's inc.
- clr_out  out  1  clear strobe, driven to every counter's clr.
- running  out  1  high while the state is RUN.
- lap_hold  out  1  high while the display is frozen.
- overflow  out  1  sticky flag: all digits wrapped.

## Operation
- States:
  - IDLE is the reset state.
  - RUN is entered from IDLE or PAUSE on start_stop.
  - PAUSE is entered from RUN on start_stop.
  - Any state goes to IDLE on clear.
- clear has priority over start_stop and lap in the same cycle.
- Prescaler div_cnt, width $clog2(TICK_DIV):
  - Increments only in RUN and wraps from TICK_DIV-1 to 0.
  - Holds its value in PAUSE, so a partial period resumes where it stopped.
  - Is zeroed in IDLE.
- tick_q is a register: tick_q <= (state==RUN && div_cnt==TICK_DIV-1). In every other case it is 0.
- inc_out = tick_q.
- clk_en_out is combinational:
  - clk_en_out[0] = tick_q.
  - clk_en_out[i] = tick_q & (&co_in[i-1:0]).
- clr_out is registered. It is 1 for exactly one cycle, the cycle after clear is sampled.
- Overflow:
  - The sticky overflow flag is set the cycle after tick_q & (&co_in).
  - The counters themselves wrap to 0.
  - overflow is cleared only by rst or clear.
  - Overflow does not stop RUN.
- lap: lap_hold toggles on a lap pulse only in RUN. The pulse is ignored in IDLE and PAUSE, but lap_hold keeps its value there. Entering IDLE clears lap_hold.
- Reset values: state=IDLE, div_cnt=0, tick_q=0, clr_out=0, lap_hold=0, overflow=0, running=0. clk_en_out and inc_out are 0 because tick_q is 0.
- A tick already registered in tick_q still takes effect in the cycle a start_stop is sampled. With clear in that same cycle, clr_out is issued one cycle later and zeroes the counters.

## Timing
- start_stop sampled at edge N: running=1 from N+1, and div_cnt counts 0..TICK_DIV-1 over cycles N+1..N+TICK_DIV.
- First tick_q=1 in cycle N+TICK_DIV+1; digit 0 updates at the end of that cycle.
- Ticks then repeat every TICK_DIV cycles while in RUN.
- Pause/resume: RUN cycles accumulate across the pause, so the next tick comes after TICK_DIV total RUN cycles.
- running, lap_hold and overflow are all registered with 1-cycle latency from the input edge.

## Configuration
- STOPWATCH_LAP_EN defined: lap input and lap_hold behave as above.
- STOPWATCH_LAP_EN undefined: the lap input is unused and lap_hold is tied to 0.

## Structure
- Package stopwatch_pkg holds:
  - the state enum: ST_IDLE, ST_RUN, ST_PAUSE;
  - the default constants TICK_DIV and NUM_DIGITS.
- Sub-module tick_gen holds the prescaler: inputs clk, rst, run, zero; output tick_q (registered).
- The top level holds the FSM, the enable ripple, clr/overflow/lap logic.

## Test plan
Simulation parameters for all scenarios: TICK_DIV=4, NUM_DIGITS=2.
- rst high 2 cycles, then low → running=0, lap_hold=0, overflow=0, clr_out=0, clk_en_out=2'b00.
- start_stop at cycle 0, co_in=0 → running=1 at cycle 1, tick_q=1 and clk_en_out=2'b01 at cycle 5, then again at 9 and 13.
- In RUN, co_in=2'b01 during a tick → clk_en_out=2'b11; co_in=2'b11 during a tick → overflow=1 the next cycle and stays set until clear.
- Pause after 2 RUN cycles, wait 10, resume → next tick exactly 2 RUN cycles after resume; no tick during PAUSE.
- clear together with start_stop in RUN → state IDLE, clr_out=1 for one cycle, overflow=0, lap_hold=0, div_cnt=0.
- STOPWATCH_LAP_EN defined, lap in RUN → lap_hold=1, second lap → 0; lap in PAUSE → no change. Macro undefined → lap_hold always 0.
